// File: rtl/bcd_display_scanner_if.sv
// Display-side bundle for bcd_display_scanner: BCD digit input, enables and
// the multiplexed 7-segment pin drive.
interface bcd_display_scanner_if;
  logic [15:0] digits;
  logic        enablen;
  logic        blink;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_sel;

  modport master (
    output digits, enablen, blink,
    input  seg, dp, digit_sel
  );

  modport slave (
    input  digits, enablen, blink,
    output seg, dp, digit_sel
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment driver for the MM:SS timer,
// with frame-coherent digit capture, leading-zero blanking, colon and blink.
module bcd_display_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 60
) (
  input  logic                  clock,
  input  logic                  clearn,
  bcd_display_scanner_if.slave  bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BCNT_MAX  = BW'(BLINK_FRAMES - 1);

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_HIDDEN  = 1'b1
  } phase_t;

  logic [PW-1:0] r_presc, w_presc;
  logic [1:0]    r_idx,   w_idx;
  logic [15:0]   r_lat,   w_lat;
  logic [BW-1:0] r_bcnt,  w_bcnt;
  phase_t        r_phase, w_phase;
  logic [6:0]    r_seg,   w_seg;
  logic          r_dp,    w_dp;
  logic [3:0]    r_sel,   w_sel;

  logic          w_tc;
  logic          w_frame;
  logic          w_blank;
  logic          w_lzb;
  logic [3:0]    w_nib;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b0111111;
      4'd1:    seg_of = 7'b0000110;
      4'd2:    seg_of = 7'b1011011;
      4'd3:    seg_of = 7'b1001111;
      4'd4:    seg_of = 7'b1100110;
      4'd5:    seg_of = 7'b1101101;
      4'd6:    seg_of = 7'b1111101;
      4'd7:    seg_of = 7'b0000111;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1101111;
      default: seg_of = 7'b1000000;
    endcase
  endfunction

  assign w_tc    = (r_presc == PRESC_MAX);
  assign w_frame = w_tc && (r_idx == 2'd3);

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_lat   <= '0;
      r_bcnt  <= '0;
      r_phase <= PH_VISIBLE;
      r_seg   <= '0;
      r_dp    <= 1'b0;
      r_sel   <= '1;
    end else begin
      r_presc <= w_presc;
      r_idx   <= w_idx;
      r_lat   <= w_lat;
      r_bcnt  <= w_bcnt;
      r_phase <= w_phase;
      r_seg   <= w_seg;
      r_dp    <= w_dp;
      r_sel   <= w_sel;
    end
  end

  // Scan state: prescaler, digit index, frame latch and blink phase.
  always_comb begin
    w_presc = r_presc + 1'b1;
    w_idx   = r_idx;
    w_lat   = r_lat;
    w_bcnt  = r_bcnt;
    w_phase = r_phase;
    if (w_tc) begin
      w_presc = '0;
      w_idx   = r_idx + 2'd1;
    end
    if (w_frame) w_lat = bus.digits;
    if (!bus.blink) begin
      w_bcnt  = '0;
      w_phase = PH_VISIBLE;
    end else if (w_frame) begin
      if (r_bcnt == BCNT_MAX) begin
        w_bcnt  = '0;
        w_phase = (r_phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
        w_bcnt = r_bcnt + 1'b1;
      end
    end
  end

  // Output drive uses the raw blink input so dropping blink is seen next clock.
  always_comb begin
    case (r_idx)
      2'd0:    w_nib = r_lat[3:0];
      2'd1:    w_nib = r_lat[7:4];
      2'd2:    w_nib = r_lat[11:8];
      default: w_nib = r_lat[15:12];
    endcase
    w_blank = bus.enablen || (bus.blink && (r_phase == PH_HIDDEN));
    w_lzb   = (r_idx == 2'd3) && (r_lat[15:12] == 4'd0);
    w_seg   = (w_blank || w_lzb) ? '0 : seg_of(w_nib);
    w_sel   = (w_blank || w_lzb) ? '1 : ~(4'b0001 << r_idx);
    w_dp    = !w_blank && (r_idx == 2'd2);
  end

  assign bus.seg       = r_seg;
  assign bus.dp        = r_dp;
  assign bus.digit_sel = r_sel;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed scoreboard bench for bcd_display_scanner with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_bcd_display_scanner;

  logic clock = 1'b0;
  logic clearn;
  bcd_display_scanner_if bus ();

  bcd_display_scanner #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clock  (clock),
    .clearn (clearn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Posedges since reset release; output after posedge k shows index ((k-1)/4)%4.
  int unsigned cyc;
  always @(posedge clock or negedge clearn) begin
    if (!clearn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                         S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101,
                         S6 = 7'b1111101, S7 = 7'b0000111, S8 = 7'b1111111,
                         S9 = 7'b1101111, SD = 7'b1000000;
  localparam logic [11:0] BLANK = {4'b1111, 1'b0, 7'b0000000};

  typedef struct {
    string       tag;
    int unsigned cyc;
    logic [11:0] word;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [11:0] vis(input int unsigned i, input logic [6:0] s);
    logic [3:0] one;
    one = 4'b0001 << i;
    return {~one, (i == 2), s};
  endfunction

  task automatic push(input string tag, input int unsigned c, input logic [11:0] w);
    exp_t e;
    e.tag  = tag;
    e.cyc  = c;
    e.word = w;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int unsigned c);
    int unsigned guard = 0;
    while (cyc < c && guard < 2000) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (cyc < c) begin
      checks++;
      errors++;
      $display("FAIL timeout: cyc=%0d required=%0d", cyc, c);
    end
  endtask

  task automatic drain();
    exp_t        e;
    logic [11:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_cyc(e.cyc);
      obs = {bus.digit_sel, bus.dp, bus.seg};
      checks++;
      assert (obs === e.word) else begin
        errors++;
        $error("FAIL %s @cyc%0d: got sel=%b dp=%b seg=%b required sel=%b dp=%b seg=%b",
               e.tag, cyc, obs[11:8], obs[7], obs[6:0], e.word[11:8], e.word[7], e.word[6:0]);
      end
    end
  endtask

  initial begin
    clearn      = 1'b0;
    bus.digits  = 16'h0000;
    bus.enablen = 1'b0;
    bus.blink   = 1'b0;
    #12;
    push("reset", 0, BLANK);
    drain();
    @(negedge clock);
    clearn = 1'b1;

    push("f0_d0", 1, vis(0, S0));
    push("f0_d1", 5, vis(1, S0));
    push("f0_d2_dp", 9, vis(2, S0));
    push("f0_d3_lzb", 13, BLANK);
    drain();

    bus.digits = 16'h1259;
    push("old_d3", 15, BLANK);
    push("new_d0", 17, vis(0, S9));
    push("new_d1", 21, vis(1, S5));
    drain();
    bus.digits = 16'h00A0;
    push("new_d2", 25, vis(2, S2));
    push("new_d3", 29, vis(3, S1));
    push("nb_d0", 33, vis(0, S0));
    push("nb_d1_dash", 37, vis(1, SD));
    push("nb_d2", 41, vis(2, S0));
    push("nb_d3_lzb", 45, BLANK);
    push("en_pre", 50, vis(0, S0));
    drain();

    bus.enablen = 1'b1;
    push("en_off_a", 51, BLANK);
    push("en_off_b", 53, BLANK);
    push("en_off_c", 55, BLANK);
    drain();
    bus.enablen = 1'b0;
    push("en_back", 56, vis(1, SD));
    push("pre_blink", 64, BLANK);
    drain();

    bus.blink = 1'b1;
    push("bl_f4_d0", 65, vis(0, S0));
    drain();
    bus.digits = 16'h1234;
    push("bl_f4_d2", 73, vis(2, S0));
    push("bl_f5_d0", 81, vis(0, S4));
    push("bl_f5_d2", 89, vis(2, S2));
    push("bl_f5_d3", 96, vis(3, S1));
    push("bl_f6_d0", 97, BLANK);
    push("bl_f6_d2", 105, BLANK);
    push("bl_f7_d0", 113, BLANK);
    drain();
    bus.digits = 16'h5678;
    push("bl_f7_d2", 121, BLANK);
    push("bl_f7_d3", 128, BLANK);
    push("bl_f8_d0", 129, vis(0, S8));
    push("bl_f8_d2", 137, vis(2, S6));
    push("bl_f9_d0", 145, vis(0, S8));
    push("bl_f9_d2", 153, vis(2, S6));
    push("bl_f10_d0", 161, BLANK);
    push("bl_f10_d2", 169, BLANK);
    push("bl_f11_d0", 180, BLANK);
    drain();
    bus.blink = 1'b0;
    push("bl_off", 181, vis(1, S7));
    push("pre_rst", 202, vis(2, S6));
    drain();

    bus.digits = 16'h0930;
    #2;
    clearn = 1'b0;
    #1;
    push("rst_async", 0, BLANK);
    drain();
    repeat (2) @(posedge clock);
    #1;
    push("rst_hold", 0, BLANK);
    drain();
    @(negedge clock);
    clearn = 1'b1;

    push("post_d0", 1, vis(0, S0));
    push("post_d1", 5, vis(1, S0));
    push("post_d2", 9, vis(2, S0));
    push("post_d3", 13, BLANK);
    push("cap_d0", 17, vis(0, S0));
    push("cap_d1", 21, vis(1, S3));
    push("cap_d2", 25, vis(2, S9));
    push("cap_d3_lzb", 29, BLANK);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
